// File: rtl/ic_rle_encoder_pkg.sv
// ---------------------------------------------------------------------------
// ic_rle_pkg : shared widths, symbol constants and the symbol record used by
//              the zero-run-length / DC-differential encoder.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ic_rle_pkg;

  localparam int COEF_W = 13;
  localparam int LANES  = 8;
  localparam int AMP_W  = COEF_W + 1;

  localparam logic [3:0] ZRL_RUN  = 4'd15;
  localparam logic [3:0] ZRL_SIZE = 4'd0;
  localparam logic [3:0] EOB_RUN  = 4'd0;
  localparam logic [3:0] EOB_SIZE = 4'd0;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_e;

  typedef struct packed {
    logic [3:0]       run;
    logic [3:0]       size;
    logic [AMP_W-1:0] amp;
    logic             dc;
    logic [1:0]       comp;
    logic             last;
  } sym_t;

  // Blocks 0 and 1 of each macroblock are luma, then one Cb and one Cr.
  function automatic comp_e comp_of(input logic [1:0] blk);
    case (blk)
      2'd2:    return COMP_CB;
      2'd3:    return COMP_CR;
      default: return COMP_Y;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ic_rle_encoder_if.sv
// ---------------------------------------------------------------------------
// ic_rle_encoder_if : beat input and symbol output bundle of the RLE encoder.
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ic_rle_encoder_if;
  import ic_rle_pkg::*;

  logic [LANES*COEF_W-1:0] x;
  logic                    x_valid;
  logic                    pred_clr;
  logic                    sym_valid;
  logic                    sym_ready;
  logic [3:0]              sym_run;
  logic [3:0]              sym_size;
  logic [AMP_W-1:0]        sym_amp;
  logic                    sym_dc;
  logic [1:0]              sym_comp;
  logic                    sym_last;
  logic                    overflow;

  modport master (
    output x, x_valid, pred_clr, sym_ready,
    input  sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_comp, sym_last, overflow
  );

  modport slave (
    input  x, x_valid, pred_clr, sym_ready,
    output sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_comp, sym_last, overflow
  );

endinterface

`default_nettype wire

// File: rtl/ic_rle_encoder_size_amp.sv
// ---------------------------------------------------------------------------
// ic_rle_size_amp : JPEG category (bit length of |v|) and amplitude bits of a
//                   signed value; ones'-complement form for negatives.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ic_rle_size_amp
  import ic_rle_pkg::*;
(
  input  logic signed [AMP_W-1:0] i_val,
  output logic        [3:0]       o_size,
  output logic        [AMP_W-1:0] o_amp
);

  logic [AMP_W-1:0] w_mag;
  logic [AMP_W-1:0] w_vm1;
  logic [AMP_W-1:0] w_mask;
  logic [3:0]       w_size;

  always_comb begin
    w_mag  = i_val[AMP_W-1] ? ((~i_val) + AMP_W'(1)) : i_val;
    w_size = 4'd0;
    for (int i = 0; i < AMP_W; i++) begin
      if (w_mag[i]) w_size = 4'(i + 1);
    end
    w_mask = (AMP_W'(1) << w_size) - AMP_W'(1);
    w_vm1  = i_val - AMP_W'(1);
    o_size = w_size;
    o_amp  = i_val[AMP_W-1] ? (w_vm1 & w_mask) : i_val;
  end

endmodule

`default_nettype wire

// File: rtl/ic_rle_encoder.sv
// ---------------------------------------------------------------------------
// ic_rle_encoder : ping-pong 8x8 block buffer feeding a DC-difference / AC
//                  zero-run symbol generator with a stallable output register.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ic_rle_encoder
  import ic_rle_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  ic_rle_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DC   = 3'd1,
    S_AC   = 3'd2,
    S_ZRL  = 3'd3,
    S_EOB  = 3'd4,
    S_FREE = 3'd5
  } state_e;

  state_e                  r_state, w_state_nx;
  logic [COEF_W-1:0]       r_bank [0:1][0:63];
  logic [1:0]              r_full;
  logic                    r_wr_ptr, r_rd_ptr;
  logic [2:0]              r_beat;
  logic [5:0]              r_k, r_run, w_k_nx, w_run_nx;
  logic [1:0]              r_blk;
  logic [COEF_W-1:0]       r_pred_y, r_pred_cb, r_pred_cr, w_pred;
  logic                    r_pend_clr, r_overflow, r_sym_valid;
  sym_t                    r_sym, w_sym;
  logic                    w_emit, w_pred_wr, w_free, w_clr, w_out_free, w_wr_ok;
  comp_e                   w_comp;
  logic [COEF_W-1:0]       w_coef;
  logic signed [AMP_W-1:0] w_diff, w_sa_in;
  logic [3:0]              w_size;
  logic [AMP_W-1:0]        w_amp;

  assign w_wr_ok    = bus.x_valid && !r_full[r_wr_ptr];
  assign w_out_free = !r_sym_valid || bus.sym_ready;
  assign w_comp     = comp_of(r_blk);
  assign w_coef     = r_bank[r_rd_ptr][r_k];

  always_comb begin
    case (w_comp)
      COMP_CB: w_pred = r_pred_cb;
      COMP_CR: w_pred = r_pred_cr;
      default: w_pred = r_pred_y;
    endcase
  end

  assign w_diff  = {w_coef[COEF_W-1], w_coef} - {w_pred[COEF_W-1], w_pred};
  assign w_sa_in = (r_state == S_DC) ? w_diff : {w_coef[COEF_W-1], w_coef};

  ic_rle_size_amp u_size_amp (
    .i_val  (w_sa_in),
    .o_size (w_size),
    .o_amp  (w_amp)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_run_nx   = r_run;
    w_emit     = 1'b0;
    w_pred_wr  = 1'b0;
    w_free     = 1'b0;
    w_clr      = 1'b0;
    w_sym      = '0;
    w_sym.comp = w_comp;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_ptr])                     w_state_nx = S_DC;
        else if (r_pend_clr && (r_full == 2'b00)) w_clr      = 1'b1;
      end
      S_DC: if (w_out_free) begin
        w_emit     = 1'b1;
        w_sym.size = w_size;
        w_sym.amp  = w_amp;
        w_sym.dc   = 1'b1;
        w_pred_wr  = 1'b1;
        w_k_nx     = 6'd1;
        w_run_nx   = 6'd0;
        w_state_nx = S_AC;
      end
      S_AC: begin
        if (w_coef == '0) begin
          // Trailing zeros never produce ZRL; they fold into the EOB.
          if (r_k == 6'd63) w_state_nx = S_EOB;
          else begin
            w_run_nx = r_run + 6'd1;
            w_k_nx   = r_k + 6'd1;
          end
        end else if (r_run >= 6'd16) begin
          w_state_nx = S_ZRL;
        end else if (w_out_free) begin
          w_emit     = 1'b1;
          w_sym.run  = r_run[3:0];
          w_sym.size = w_size;
          w_sym.amp  = w_amp;
          w_sym.last = (r_k == 6'd63);
          w_run_nx   = 6'd0;
          if (r_k == 6'd63) w_state_nx = S_FREE;
          else              w_k_nx     = r_k + 6'd1;
        end
      end
      S_ZRL: if (w_out_free) begin
        w_emit     = 1'b1;
        w_sym.run  = ZRL_RUN;
        w_sym.size = ZRL_SIZE;
        w_run_nx   = r_run - 6'd16;
        w_state_nx = S_AC;
      end
      S_EOB: if (w_out_free) begin
        w_emit     = 1'b1;
        w_sym.run  = EOB_RUN;
        w_sym.size = EOB_SIZE;
        w_sym.last = 1'b1;
        w_state_nx = S_FREE;
      end
      S_FREE: begin
        w_free     = 1'b1;
        w_k_nx     = 6'd0;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Coefficient storage carries no reset; validity lives in r_full.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int l = 0; l < LANES; l++) begin
        r_bank[r_wr_ptr][{r_beat, 3'(l)}] <= bus.x[l*COEF_W +: COEF_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_full      <= 2'b00;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_beat      <= 3'd0;
      r_overflow  <= 1'b0;
      r_k         <= 6'd0;
      r_run       <= 6'd0;
      r_blk       <= 2'd0;
      r_pred_y    <= '0;
      r_pred_cb   <= '0;
      r_pred_cr   <= '0;
      r_pend_clr  <= 1'b0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
    end else begin
      if (bus.x_valid && r_full[r_wr_ptr]) r_overflow <= 1'b1;
      if (w_wr_ok) begin
        r_beat <= r_beat + 3'd1;
        if (r_beat == 3'd7) begin
          r_full[r_wr_ptr] <= 1'b1;
          r_wr_ptr         <= ~r_wr_ptr;
        end
      end
      if (w_free) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
        r_blk            <= r_blk + 2'd1;
      end
      r_k   <= w_k_nx;
      r_run <= w_run_nx;
      if (w_pred_wr) begin
        case (w_comp)
          COMP_CB: r_pred_cb <= w_coef;
          COMP_CR: r_pred_cr <= w_coef;
          default: r_pred_y  <= w_coef;
        endcase
      end
      if (w_clr) begin
        r_pred_y  <= '0;
        r_pred_cb <= '0;
        r_pred_cr <= '0;
        r_blk     <= 2'd0;
      end
      r_pend_clr <= (r_pend_clr && !w_clr) || bus.pred_clr;
      if (w_emit) begin
        r_sym       <= w_sym;
        r_sym_valid <= 1'b1;
      end else if (bus.sym_ready) begin
        r_sym_valid <= 1'b0;
      end
    end
  end

  assign bus.sym_valid = r_sym_valid;
  assign bus.sym_run   = r_sym.run;
  assign bus.sym_size  = r_sym.size;
  assign bus.sym_amp   = r_sym.amp;
  assign bus.sym_dc    = r_sym.dc;
  assign bus.sym_comp  = r_sym.comp;
  assign bus.sym_last  = r_sym.last;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ic_rle_encoder.sv
// ---------------------------------------------------------------------------
// tb_ic_rle_encoder : directed blocks against a symbol-list model of the
//                     JPEG zero-run / DC-difference rules.
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ic_rle_encoder;
  import ic_rle_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ic_rle_encoder_if bus ();

  ic_rle_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  sym_t exp_q[$];
  int   blk_c[64];
  int   m_pred[3];
  int   m_blk;
  sym_t held;
  bit   hold_armed = 1'b0;

  function automatic sym_t lit(input int run, input int size, input int amp,
                               input int dc, input int comp, input int last);
    sym_t s;
    s.run  = 4'(run);
    s.size = 4'(size);
    s.amp  = 14'(amp);
    s.dc   = 1'(dc);
    s.comp = 2'(comp);
    s.last = 1'(last);
    return s;
  endfunction

  function automatic sym_t mk(input int run, input int v, input int dc,
                              input int comp, input int last);
    int mag, size, amp;
    mag  = (v < 0) ? -v : v;
    size = 0;
    while (mag > 0) begin
      size++;
      mag = mag / 2;
    end
    amp = (v > 0) ? v : ((v - 1) & ((1 << size) - 1));
    return lit(run, size, amp, dc, comp, last);
  endfunction

  function automatic sym_t dut_sym();
    sym_t s;
    s.run  = bus.sym_run;
    s.size = bus.sym_size;
    s.amp  = bus.sym_amp;
    s.dc   = bus.sym_dc;
    s.comp = bus.sym_comp;
    s.last = bus.sym_last;
    return s;
  endfunction

  task automatic chk_sym(input string name, input sym_t got, input sym_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got run=%0d size=%0d amp=%0h dc=%0d comp=%0d last=%0d, expected run=%0d size=%0d amp=%0h dc=%0d comp=%0d last=%0d",
               name, got.run, got.size, got.amp, got.dc, got.comp, got.last,
               exp.run, exp.size, exp.amp, exp.dc, exp.comp, exp.last);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Expected symbol list for blk_c, from the JPEG run/size rules.
  task automatic model_block();
    int comp, last_nz, run;
    comp = (m_blk < 2) ? 0 : m_blk - 1;
    exp_q.push_back(mk(0, blk_c[0] - m_pred[comp], 1, comp, 0));
    m_pred[comp] = blk_c[0];
    last_nz = 0;
    for (int i = 1; i < 64; i++) begin
      if (blk_c[i] != 0) begin
        run = i - last_nz - 1;
        while (run >= 16) begin
          exp_q.push_back(lit(15, 0, 0, 0, comp, 0));
          run -= 16;
        end
        exp_q.push_back(mk(run, blk_c[i], 0, comp, (i == 63) ? 1 : 0));
        last_nz = i;
      end
    end
    if (last_nz != 63) exp_q.push_back(lit(0, 0, 0, 0, comp, 1));
    m_blk = (m_blk + 1) % 4;
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk_c[i] = 0;
  endtask

  task automatic dense_blk();
    for (int i = 0; i < 64; i++) blk_c[i] = ((i % 3) == 0) ? -(i + 1) : (i + 1);
  endtask

  task automatic send_block(input bit chk_lat);
    for (int b = 0; b < 8; b++) begin
      @(posedge clk); #1;
      for (int l = 0; l < 8; l++) bus.x[13*l +: 13] = 13'(blk_c[8*b+l]);
      bus.x_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.x_valid = 1'b0;
    if (chk_lat) begin
      chk_int("lat_edge0", int'(bus.sym_valid), 0);
      @(posedge clk); #1;
      chk_int("lat_edge1", int'(bus.sym_valid), 0);
      @(posedge clk); #1;
      chk_int("lat_edge2", int'(bus.sym_valid), 1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk_int("drain_outstanding", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : p_cmp
    sym_t g;
    if (!reset_n) begin
      hold_armed = 1'b0;
    end else begin
      g = dut_sym();
      if (hold_armed) begin
        chk_int("hold_valid", int'(bus.sym_valid), 1);
        chk_sym("hold_stable", g, held);
      end
      if (bus.sym_valid && bus.sym_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_symbol: got run=%0d size=%0d amp=%0h dc=%0d last=%0d, expected none",
                   g.run, g.size, g.amp, g.dc, g.last);
        end else begin
          chk_sym("symbol", g, exp_q.pop_front());
        end
      end
      hold_armed = bus.sym_valid && !bus.sym_ready;
      held       = g;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bus.x         = '0;
    bus.x_valid   = 1'b0;
    bus.pred_clr  = 1'b0;
    bus.sym_ready = 1'b1;
    m_pred        = '{0, 0, 0};
    m_blk         = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("rst_sym_valid", int'(bus.sym_valid), 0);
    chk_sym("rst_sym", dut_sym(), lit(0, 0, 0, 0, 0, 0));
    chk_int("rst_overflow", int'(bus.overflow), 0);
    reset_n = 1'b1;

    // All-zero first Y block
    clear_blk();
    model_block();
    chk_int("zero_model_len", exp_q.size(), 2);
    chk_sym("zero_model_dc", exp_q[0], lit(0, 0, 0, 1, 0, 0));
    chk_sym("zero_model_eob", exp_q[1], lit(0, 0, 0, 0, 0, 1));
    send_block(1'b1);
    drain();

    // 5, -3 then zeros (second Y block, pred 0)
    clear_blk();
    blk_c[0] = 5;
    blk_c[1] = -3;
    model_block();
    chk_sym("m53_model_dc", exp_q[0], lit(0, 3, 5, 1, 0, 0));
    chk_sym("m53_model_ac", exp_q[1], lit(0, 2, 0, 0, 0, 0));
    chk_sym("m53_model_eob", exp_q[2], lit(0, 0, 0, 0, 0, 1));
    send_block(1'b0);
    drain();

    // Frame start, then two Y blocks: DC 5 followed by DC 2
    @(posedge clk); #1;
    bus.pred_clr = 1'b1;
    @(posedge clk); #1;
    bus.pred_clr = 1'b0;
    m_pred = '{0, 0, 0};
    m_blk  = 0;
    repeat (2) @(posedge clk);
    clear_blk();
    blk_c[0] = 5;
    model_block();
    send_block(1'b0);
    drain();
    clear_blk();
    blk_c[0] = 2;
    model_block();
    chk_sym("dcdiff_model", exp_q[0], lit(0, 2, 0, 1, 0, 0));
    send_block(1'b0);
    drain();

    // Cb: only coef 40
    clear_blk();
    blk_c[40] = 1;
    model_block();
    chk_int("c40_model_len", exp_q.size(), 5);
    chk_sym("c40_model_zrl", exp_q[1], lit(15, 0, 0, 0, 1, 0));
    chk_sym("c40_model_ac", exp_q[3], lit(7, 1, 1, 0, 1, 0));
    chk_sym("c40_model_eob", exp_q[4], lit(0, 0, 0, 0, 1, 1));
    send_block(1'b0);
    drain();

    // Cr: only coef 63 = -1
    clear_blk();
    blk_c[63] = -1;
    model_block();
    chk_int("c63_model_len", exp_q.size(), 5);
    chk_sym("c63_model_zrl", exp_q[3], lit(15, 0, 0, 0, 2, 0));
    chk_sym("c63_model_last", exp_q[4], lit(14, 1, 0, 0, 2, 1));
    send_block(1'b0);
    drain();

    // Backpressure: stall mid-block while two more blocks arrive
    dense_blk();
    model_block();
    chk_sym("dense_model_last", exp_q[63], lit(0, 7, 63, 0, 0, 1));
    send_block(1'b0);
    repeat (4) @(posedge clk);
    #1;
    bus.sym_ready = 1'b0;
    clear_blk();
    blk_c[0]  = -100;
    blk_c[5]  = 7;
    blk_c[20] = -1000;
    blk_c[37] = 4095;
    blk_c[38] = -4096;
    model_block();
    send_block(1'b0);
    chk_int("ovf_after_second", int'(bus.overflow), 0);
    for (int i = 0; i < 64; i++) blk_c[i] = 100 + i;
    send_block(1'b0);
    chk_int("ovf_after_third", int'(bus.overflow), 1);
    repeat (2) @(posedge clk);
    #1;
    bus.sym_ready = 1'b1;
    drain();
    chk_int("ovf_sticky", int'(bus.overflow), 1);

    // Reset in the middle of encoding a block
    dense_blk();
    model_block();
    send_block(1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk_int("midrst_sym_valid", int'(bus.sym_valid), 0);
    chk_sym("midrst_sym", dut_sym(), lit(0, 0, 0, 0, 0, 0));
    chk_int("midrst_overflow", int'(bus.overflow), 0);
    reset_n = 1'b1;
    m_pred  = '{0, 0, 0};
    m_blk   = 0;
    clear_blk();
    blk_c[0] = -7;
    model_block();
    chk_sym("post_rst_model_dc", exp_q[0], lit(0, 3, 0, 1, 0, 0));
    send_block(1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ic_rle_encoder.md
# ic_rle_encoder

Zero-run-length and DC-differential encoder directly downstream of the quantise/zig-zag stage in the JPEG compression path. It consumes 8×13-bit quantised coefficients per beat, 8 beats per 8×8 block, already in zig-zag order. It emits one JPEG symbol per handshake: a DC difference, an AC (run, size, amplitude), a ZRL, or an EOB. Ping-pong block buffering decouples the burst input from the per-symbol output, and the Huffman stage consumes the symbols.

## Interface
- COEF_W, 13, coefficient width, two's complement
- LANES, 8, coefficients per input beat
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- x  in  104  beat; lane i = bits [13i+12:13i]; beat b carries zig-zag indices 8b..8b+7
- x_valid  in  1  beat valid (upstream outputready); no backpressure
- pred_clr  in  1  pulse; clears DC predictors and block counter (frame start)
- sym_valid  out  1  symbol valid
- sym_ready  in  1  downstream accept
- sym_run  out  4  zero run preceding coefficient (0 for DC/EOB; 15 for ZRL)
- sym_size  out  4  JPEG category 0..13
- sym_amp  out  14  amplitude bits, valid in [size-1:0], upper bits zero
- sym_dc  out  1  symbol is DC difference
- sym_comp  out  2  0=Y, 1=Cb, 2=Cr
- sym_last  out  1  final symbol of block (EOB, or AC at index 63)
- overflow  out  1  sticky; beat arrived with both banks full

## Operation
- Two banks of 64×13. Write bank fills with beat counter 0..7; on beat 7 bank marked full, write pointer toggles. Beat with target bank full: dropped, overflow set (cleared only by reset).
- Block counter (2-bit, wraps): blocks 0,1→Y, 2→Cb, 3→Cr. Advanced when a block finishes encoding.
- Predictors pred_y/pred_cb/pred_cr, 13-bit, reset 0.
- FSM states IDLE, DC, AC, ZRL, EOB, FREE:
  - IDLE: read bank full → DC.
  - DC: diff = coef[0] − pred[comp] (14-bit signed); emit (0, size, amp, dc=1); pred[comp] ← coef[0]; k←1, run←0 → AC.
  - AC, one index per cycle: coef[k]==0 → run++, k++ (no symbol). Nonzero and run≥16 → ZRL. Nonzero and run<16 → emit (run, size, amp), run←0, k++. After k=63: if last emit was coef 63 → FREE (sym_last on that symbol), else → EOB.
  - ZRL: emit (15,0,0), run −=16 → AC at same k.
  - EOB: emit (0,0,0, last=1) → FREE.
  - FREE: clear bank full, toggle read pointer, advance block counter → IDLE.
- Trailing zero runs ≥16 produce no ZRL; EOB only.
- size = bit length of |v| (0 for v=0). amp = v if v>0, else (v−1) masked to size bits.
- pred_clr: pending latch; applied when IDLE and no bank full; clears predictors and block counter.
- Any emit with sym_valid && !sym_ready stalls FSM; output register holds all sym_* stable.

## Timing
- Reset: sym_valid=0, all sym_* 0, overflow=0, banks empty, pointers 0, FSM IDLE, pending pred_clr 0.
- Bank full visible on cycle after beat 7 edge; DC sym_valid asserts on 2nd edge after beat 7 capture.
- Throughput: one coefficient scanned or one symbol issued per cycle; an all-zero AC block takes 1 (DC) + 63 scan + 1 (EOB) + FREE.
- Simultaneous beat into bank A and FREE of bank B: both honoured.
- Reset mid-block: discard all buffered data, outputs to reset values the next cycle.

## Structure
- Package ic_rle_pkg: COEF_W, LANES, ZRL run/size constants, EOB constant, component encodings, symbol struct.
- Sub-module ic_rle_size_amp: combinational 14-bit value → (size, amp), shared by DC and AC paths.

## Test plan
- Block all zeros, first Y block: DC (0,0,0,dc=1,comp=0), EOB (0,0,0,last=1); no other symbols.
- coef[0]=5, coef[1]=−3, rest 0, Y: DC size 3 amp 5; AC run0 size2 amp 2'b00; EOB.
- Second Y block coef[0]=2 after first with 5: DC diff −3 → size 2 amp 2'b00.
- Only coef[40]=1: 2 ZRL (15,0), then (7,1,1), then EOB.
- Only coef[63]=−1: 3 ZRL, (14,1,0) with sym_last=1, no EOB.
- sym_ready low 10 cycles mid-block while next 8 beats arrive: outputs held, second bank fills, no overflow; a third block sent immediately after sets overflow.
